// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for div.w / mod.w / div.wu / mod.wu.
// Handshaked on both sides; a flush cancels whatever is in flight.
//
// state | meaning
// IDLE  | ready for a request, result forced to zero
// CALC  | 32 shift-subtract steps on the latched magnitudes
// DONE  | sign-corrected result presented until taken by the consumer
module div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        div_valid,
   output logic        div_ready,
   input  logic        div_signed,
   input  logic        div_rem,
   input  logic [31:0] div_src1,
   input  logic [31:0] div_src2,
   input  logic        flush,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] div_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  count;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] src1_lat;
   logic        op_rem;
   logic        neg_quo;
   logic        neg_rem;
   logic        dvs_zero;

   logic        src1_neg;
   logic        src2_neg;
   logic [31:0] src1_mag;
   logic [31:0] src2_mag;
   logic [33:0] trial;
   logic        trial_neg;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Operand magnitudes at accept time; raw values pass through for unsigned ops.
   always_comb begin
      src1_neg = div_signed & div_src1[31];
      src2_neg = div_signed & div_src2[31];
      src1_mag = src1_neg ? (~div_src1 + 32'd1) : div_src1;
      src2_mag = src2_neg ? (~div_src2 + 32'd1) : div_src2;
   end

   // Trial subtract of the divisor from the shifted partial remainder. The
   // shifted remainder needs 33 bits; one extra guard bit carries the sign.
   always_comb begin
      trial     = {1'b0, rem, dvd[31]} - {2'b00, dvs};
      trial_neg = trial[33];
   end

   // Control FSM and datapath registers; reset wins over flush, flush over everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= 5'd0;
         quo      <= 32'd0;
         rem      <= 32'd0;
         dvd      <= 32'd0;
         dvs      <= 32'd0;
         src1_lat <= 32'd0;
         op_rem   <= 1'b0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         dvs_zero <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (div_valid) begin
                  op_rem   <= div_rem;
                  neg_quo  <= src1_neg ^ src2_neg;
                  neg_rem  <= src1_neg;
                  dvd      <= src1_mag;
                  dvs      <= src2_mag;
                  src1_lat <= div_src1;
                  dvs_zero <= (div_src2 == 32'd0);
                  quo      <= 32'd0;
                  rem      <= 32'd0;
                  count    <= 5'd0;
                  state    <= CALC;
               end
            end
            CALC: begin
               rem   <= trial_neg ? {rem[30:0], dvd[31]} : trial[31:0];
               quo   <= {quo[30:0], ~trial_neg};
               dvd   <= {dvd[30:0], 1'b0};
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sign correction and divide-by-zero override; the registers are frozen in DONE so the result is stable.
   always_comb begin
      quo_fix = neg_quo ? (~quo + 32'd1) : quo;
      rem_fix = neg_rem ? (~rem + 32'd1) : rem;
      if (dvs_zero) begin
         quo_fix = 32'hFFFF_FFFF;
         rem_fix = src1_lat;
      end
      div_ready  = (state == IDLE);
      res_valid  = (state == DONE);
      div_result = 32'd0;
      if (state == DONE) begin
         div_result = op_rem ? rem_fix : quo_fix;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with an arithmetic reference model and a per-cycle output checker.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        div_valid;
   logic        div_ready;
   logic        div_signed;
   logic        div_rem;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        flush;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] div_result;

   int          checks = 0;
   int          failures = 0;
   logic        started = 1'b0;
   logic        exp_pending = 1'b0;
   logic [31:0] exp_result = 32'd0;

   div_unit dut (
      .clk        (clk),
      .reset      (reset),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .div_signed (div_signed),
      .div_rem    (div_rem),
      .div_src1   (div_src1),
      .div_src2   (div_src2),
      .flush      (flush),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .div_result (div_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, req);
      end
   endtask

   // Reference: 64-bit arithmetic avoids the signed overflow case; C-style truncating division.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic r);
      longint na, nb, q, m;
      if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
      if (s) begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
      end else begin
         na = longint'({32'd0, a});
         nb = longint'({32'd0, b});
      end
      q = na / nb;
      m = na % nb;
      return r ? m[31:0] : q[31:0];
   endfunction

   // Every cycle: a valid result must be expected and match the model; otherwise the result reads zero.
   always @(negedge clk) begin
      if (started) begin
         if (res_valid) begin
            chk("cmp_pending", {31'd0, exp_pending}, 32'd1);
            chk("cmp_result", div_result, exp_result);
         end else begin
            chk("cmp_idle_zero", div_result, 32'd0);
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                         input logic [31:0] lit, input int hold, input bit leave);
      int          lat;
      logic [31:0] held;
      chk("ready_before", {31'd0, div_ready}, 32'd1);
      chk("model_pin", model(a, b, s, r), lit);
      exp_result = model(a, b, s, r);
      div_src1   = a;
      div_src2   = b;
      div_signed = s;
      div_rem    = r;
      div_valid  = 1'b1;
      @(posedge clk); #1;
      div_valid   = 1'b0;
      div_src1    = $urandom;
      div_src2    = $urandom;
      div_signed  = ~s;
      div_rem     = ~r;
      exp_pending = 1'b1;
      chk("busy_ready", {31'd0, div_ready}, 32'd0);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (res_valid) begin
            lat = k + 1;
            break;
         end
      end
      chk("latency", lat, 33);
      if (lat == 0) begin
         exp_pending = 1'b0;
         return;
      end
      held = div_result;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, res_valid}, 32'd1);
         chk("hold_result", div_result, held);
         chk("hold_ready", {31'd0, div_ready}, 32'd0);
      end
      if (!leave) begin
         res_ready = 1'b1;
         @(posedge clk); #1;
         res_ready   = 1'b0;
         exp_pending = 1'b0;
         chk("ready_after", {31'd0, div_ready}, 32'd1);
         chk("valid_after", {31'd0, res_valid}, 32'd0);
      end
   endtask

   initial begin
      reset      = 1'b1;
      div_valid  = 1'b0;
      div_signed = 1'b0;
      div_rem    = 1'b0;
      div_src1   = 32'd0;
      div_src2   = 32'd0;
      flush      = 1'b0;
      res_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      started = 1'b1;
      chk("rst_ready", {31'd0, div_ready}, 32'd1);
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_result", div_result, 32'd0);

      run_op(32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, 0, 0);
      run_op(32'd100, 32'd7, 1'b0, 1'b1, 32'h0000_0002, 0, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 0, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h7FFF_FFFC, 0, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'h0000_0001, 0, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 0, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 0, 0);
      run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 0);
      run_op(32'h1234_5678, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 0, 0);
      run_op(32'h1234_5678, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, 0);
      run_op(32'h1234_5678, 32'd0, 1'b1, 1'b1, 32'h1234_5678, 0, 0);
      run_op(32'd17, 32'hFFFF_FFFB, 1'b1, 1'b1, 32'h0000_0002, 0, 0);

      // Backpressure, then a back-to-back request right after the handshake.
      run_op(32'd1000, 32'd33, 1'b0, 1'b0, 32'h0000_001E, 5, 0);
      run_op(32'hFFFF_FC18, 32'd33, 1'b1, 1'b1, 32'hFFFF_FFF6, 0, 0);

      // Flush sampled on the tenth CALC edge; the cancelled op must never report.
      div_src1   = 32'd500;
      div_src2   = 32'd3;
      div_signed = 1'b0;
      div_rem    = 1'b0;
      div_valid  = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready", {31'd0, div_ready}, 32'd1);
      chk("flush_valid", {31'd0, res_valid}, 32'd0);
      run_op(32'd81, 32'd9, 1'b0, 1'b0, 32'h0000_0009, 0, 0);

      // Request coinciding with flush in IDLE is dropped.
      div_src1  = 32'd9;
      div_src2  = 32'd3;
      div_valid = 1'b1;
      flush     = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
      flush     = 1'b0;
      chk("flush_accept_ready", {31'd0, div_ready}, 32'd1);
      repeat (36) begin
         @(posedge clk); #1;
      end
      chk("flush_accept_idle", {31'd0, div_ready}, 32'd1);

      // Reset while a result is waiting unclaimed.
      run_op(32'd50, 32'd5, 1'b0, 1'b0, 32'h0000_000A, 2, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      exp_pending = 1'b0;
      reset       = 1'b0;
      chk("rst_done_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_done_result", div_result, 32'd0);
      chk("rst_done_ready", {31'd0, div_ready}, 32'd1);
      run_op(32'd7, 32'd7, 1'b1, 1'b0, 32'h0000_0001, 0, 0);

      started = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EXE stage, executing div.w, mod.w, div.wu and mod.wu, which the single-cycle ALU cannot perform. It contains a restoring shift-subtract datapath, a 32-step iteration counter and a three-state FSM. It uses valid/ready handshakes on both sides. The EXE stage stalls while a result is pending. A pipeline flush (exception or branch) cancels the operation in flight.

## Interface
- Parameters: none; data width fixed at 32.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- div_valid  in  1  request valid from EXE
- div_ready  out  1  unit idle, can accept a request
- div_signed  in  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu)
- div_rem  in  1  1 = return remainder (mod), 0 = return quotient (div)
- div_src1  in  32  dividend
- div_src2  in  32  divisor
- flush  in  1  cancel any operation, discard result
- res_valid  out  1  div_result valid
- res_ready  in  1  consumer takes result
- div_result  out  32  quotient or remainder

## Operation
- FSM states are IDLE, CALC and DONE. Reset enters IDLE.
- IDLE:
  - div_ready=1.
  - Accept on div_valid & div_ready & ~flush.
  - On accept, latch op bits, the sign of each source, |src1| and |src2| (magnitudes only when div_signed=1, raw values otherwise), and whether divisor==0.
  - Clear the quotient and partial-remainder registers and the counter. Go to CALC.
- CALC:
  - Each cycle, shift {rem,quo} left by 1, bringing in the next dividend bit from the MSB down.
  - Trial-subtract using a 33-bit subtract. If the result is non-negative, keep the difference and set quo[0]=1.
  - The counter runs 0..31. When counter==31 the step executes and the FSM goes to DONE.
  - div_src* changes during CALC are ignored.
- DONE:
  - res_valid=1 and div_result holds its value stable.
  - On res_ready, go to IDLE.
- Sign correction (combinational in DONE):
  - The quotient is negated iff div_signed and the source signs differ.
  - The remainder is negated iff div_signed and the dividend is negative.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (natural two's-complement wrap, no trap).
- Divisor zero (both signednesses): quotient 0xFFFFFFFF, remainder = div_src1 as latched. The 32 cycles still elapse, so latency is uniform.
- Priorities:
  - reset over flush.
  - flush over accept, iteration and res_ready.
  - When flush is high in any state, the FSM is IDLE next cycle with res_valid=0 and no result delivered.
- Only one operation is in flight. There is no accept in CALC or DONE.

## Timing
- Reset values: state=IDLE, div_ready=1, res_valid=0, div_result=0, counter=0, internal quotient/remainder=0.
- div_result is forced to 0 whenever the state is not DONE.
- Accept edge = cycle 0. CALC occupies cycles 1..32. res_valid first rises in cycle 33 (latency 33).
- A handshake in cycle 33 (res_ready=1) puts the FSM in IDLE in cycle 34, so div_ready=1 in cycle 34. Best-case throughput is one operation per 34 cycles.
- While res_ready=0, DONE holds indefinitely with div_result constant and div_ready=0.
- flush in cycle k gives IDLE in cycle k+1. A new request can be accepted in cycle k+1.
- reset mid-operation gives the reset values on the next cycle. No partial result is ever visible.
- div_valid with flush in the same IDLE cycle: not accepted, div_ready stays 1.

## Test plan
- Unsigned, after reset:
  - 100/7 with div_rem=0: res_valid in exactly cycle 33, result 0x0000000E.
  - Same operands with div_rem=1: result 0x00000002.
- Signed:
  - 0xFFFFFFF9 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Same operands unsigned: quotient 0x7FFFFFFC, remainder 0x00000001.
- Corner operands:
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0x00000000.
  - 0x12345678 / 0, both signednesses: quotient 0xFFFFFFFF, remainder 0x12345678, still at cycle 33.
- Backpressure:
  - Hold res_ready=0 for 5 cycles after res_valid. res_valid and div_result stay stable and div_ready stays 0.
  - Release: div_ready=1 the cycle after the handshake. A back-to-back request is then accepted and returns the correct result.
- Flush:
  - Assert flush in CALC cycle 10: IDLE next cycle, res_valid never rises.
  - A new request accepted immediately after returns its own correct result 33 cycles later.
- Reset in DONE with res_ready=0: next cycle res_valid=0, div_result=0, div_ready=1.
